// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// FSM state encoding, SYSTEM opcode, PC step and a canonical NOP word.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALT,
        ST_FAULT
    } fetch_state_t;

    localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
    localparam int          PC_INC     = 4;
    localparam logic [31:0] NOP        = 32'h0000_0013;

endpackage

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the byte fetch address,
// registers the returned word and hands it to decode over valid/ready.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   start                    leave IDLE
//   imem_addr / imem_data    fetch address out, combinational word in
//   redirect_valid/_target   taken branch/jump
//   out_valid/out_ready      decode handshake
//   out_instr, out_pc        presented instruction and its address
//   halted, fault            HALT / FAULT state flags
//   fault_addr               misaligned redirect target
//   fetch_cnt                saturating count of accepted instructions
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                 ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int                 CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              halted,
    output logic              fault,
    output logic [ADDR_W-1:0] fault_addr,
    output logic [CNT_W-1:0]  fetch_cnt
);

    fetch_state_t      state_q;
    fetch_state_t      state_d;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              valid_q;
    logic              valid_d;
    logic [31:0]       instr_q;
    logic [31:0]       instr_d;
    logic [ADDR_W-1:0] opc_q;
    logic [ADDR_W-1:0] opc_d;
    logic [ADDR_W-1:0] fa_q;
    logic [ADDR_W-1:0] fa_d;
    logic [CNT_W-1:0]  cnt_q;

    logic accept;
    logic redir;
    logic redir_ok;
    logic load;
    logic is_sys;

    assign accept   = valid_q & out_ready;
    assign redir    = redirect_valid &
                      ((state_q == ST_RUN) |
                       (state_q == ST_HALT));
    assign redir_ok = (redirect_target[1:0] == 2'b00);
    // Redirect outranks a load, so load is masked by it.
    assign load     = (state_q == ST_RUN) & ~redir &
                      (~valid_q | out_ready);
    assign is_sys   = (imem_data[6:0] == OPC_SYSTEM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (redir) begin
                    state_d = redir_ok ? ST_RUN
                                       : ST_FAULT;
                end else if (load && is_sys) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (redir) begin
                    state_d = redir_ok ? ST_RUN
                                       : ST_FAULT;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        opc_d   = opc_q;
        fa_d    = fa_q;
        unique case (1'b1)
            redir: begin
                valid_d = 1'b0;
                if (redir_ok) begin
                    pc_d = redirect_target;
                end else begin
                    fa_d = redirect_target;
                end
            end
            load: begin
                valid_d = 1'b1;
                instr_d = imem_data;
                opc_d   = pc_q;
                // A SYSTEM word parks the PC on itself.
                if (!is_sys) begin
                    pc_d = pc_q + ADDR_W'(PC_INC);
                end
            end
            default: begin
                if (accept) begin
                    valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= '0;
            opc_q   <= '0;
            fa_q    <= '0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            opc_q   <= opc_d;
            fa_q    <= fa_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign imem_addr  = pc_q;
    assign out_valid  = valid_q;
    assign out_instr  = instr_q;
    assign out_pc     = opc_q;
    assign halted     = (state_q == ST_HALT);
    assign fault      = (state_q == ST_FAULT);
    assign fault_addr = fa_q;
    assign fetch_cnt  = cnt_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit: directed scenarios plus a randomized
// run checked against a behavioural model of the fetch rules.
module tb_inst_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [7:0]  redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [7:0]  out_pc;
    logic        halted;
    logic        fault;
    logic [7:0]  fault_addr;
    logic [15:0] fetch_cnt;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [256];

    always #5 clk = ~clk;

    assign imem_data = {mem[imem_addr + 8'd3],
                        mem[imem_addr + 8'd2],
                        mem[imem_addr + 8'd1],
                        mem[imem_addr]};

    inst_fetch_unit #(
        .ADDR_W  (8),
        .RESET_PC(8'h00),
        .CNT_W   (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted),
        .fault          (fault),
        .fault_addr     (fault_addr),
        .fetch_cnt      (fetch_cnt)
    );

    // Behavioural model: mode 0=idle 1=run 2=halt 3=fault
    int          m_mode;
    int          m_pc;
    bit          m_ov;
    logic [31:0] m_instr;
    int          m_opc;
    int          m_fa;
    int          m_cnt;

    function automatic void put_word(int a, logic [31:0] w);
        for (int b = 0; b < 4; b++) begin
            mem[(a + b) % 256] = w[8*b +: 8];
        end
    endfunction

    function automatic logic [31:0] get_word(int a);
        logic [31:0] w = 0;
        for (int b = 0; b < 4; b++) begin
            w = w | (32'(mem[(a + b) % 256]) << (8 * b));
        end
        return w;
    endfunction

    function automatic void fill_nops();
        for (int a = 0; a < 256; a += 4) begin
            put_word(a, NOP);
        end
    endfunction

    function automatic void model_reset();
        m_mode  = 0;
        m_pc    = 0;
        m_ov    = 0;
        m_instr = 0;
        m_opc   = 0;
        m_fa    = 0;
        m_cnt   = 0;
    endfunction

    // Advance the model by one clock using the inputs now applied.
    function automatic void model_step();
        bit          acc;
        logic [31:0] w;
        acc = m_ov && out_ready;
        if (acc && m_cnt < 65535) m_cnt++;
        if (m_mode == 0) begin
            if (start) m_mode = 1;
        end else if (m_mode == 3) begin
            // stuck until reset
        end else if (redirect_valid) begin
            m_ov = 0;
            if (redirect_target % 4 == 0) begin
                m_pc   = redirect_target;
                m_mode = 1;
            end else begin
                m_fa   = redirect_target;
                m_mode = 3;
            end
        end else if (m_mode == 1 && (!m_ov || out_ready)) begin
            w       = get_word(m_pc);
            m_instr = w;
            m_opc   = m_pc;
            m_ov    = 1;
            if ((w & 32'h7f) == 32'h73) m_mode = 2;
            else m_pc = (m_pc + 4) % 256;
        end else if (acc) begin
            m_ov = 0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        start           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 8'h00;
        out_ready       = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        start           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 8'h00;
        out_ready       = 1'b0;
        fill_nops();
        rst_n = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_valid: got %b want 0", out_valid);
        end
        checks++;
        if ({out_instr, out_pc} !== 40'h0) begin
            failures++;
            $display("FAIL rst_out: got %h/%h want 0/0",
                     out_instr, out_pc);
        end
        checks++;
        if ({halted, fault, fault_addr} !== 10'h0) begin
            failures++;
            $display("FAIL rst_flags: got %b %b %h want 0 0 00",
                     halted, fault, fault_addr);
        end
        checks++;
        if (fetch_cnt !== 16'd0 || imem_addr !== 8'h00) begin
            failures++;
            $display("FAIL rst_cnt_pc: got %0d/%h want 0/00",
                     fetch_cnt, imem_addr);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        logic [7:0]  epc [3];
        logic [31:0] ew  [3];
        epc = '{8'h00, 8'h04, 8'h08};
        ew  = '{32'h00002083, 32'h00402103, 32'h00802183};
        do_reset();
        fill_nops();
        for (int i = 0; i < 3; i++) put_word(epc[i], ew[i]);
        out_ready = 1'b1;
        start_pulse();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stream_first_idle: got %b want 0",
                     out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== epc[i] ||
                out_instr !== ew[i]) begin
                failures++;
                $display("FAIL stream_%0d: got %b %h %h want 1 %h %h",
                         i, out_valid, out_pc, out_instr,
                         epc[i], ew[i]);
            end
        end
        tick();
        checks++;
        if (fetch_cnt !== 16'd3) begin
            failures++;
            $display("FAIL stream_cnt: got %0d want 3", fetch_cnt);
        end
    endtask

    task automatic test_stall();
        do_reset();
        fill_nops();
        put_word(0, 32'h00002083);
        put_word(4, 32'h00402103);
        put_word(8, 32'h00802183);
        out_ready = 1'b1;
        start_pulse();
        tick();
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_pc !== 8'h04 || out_instr !== 32'h00402103 ||
                imem_addr !== 8'h08 || fetch_cnt !== 16'd1 ||
                out_valid !== 1'b1) begin
                failures++;
                $display("FAIL stall_%0d: got %h %h %h %0d want 04 00402103 08 1",
                         i, out_pc, out_instr, imem_addr, fetch_cnt);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_pc !== 8'h08 || out_instr !== 32'h00802183 ||
            fetch_cnt !== 16'd2) begin
            failures++;
            $display("FAIL stall_resume: got %h %h %0d want 08 00802183 2",
                     out_pc, out_instr, fetch_cnt);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        fill_nops();
        out_ready = 1'b1;
        start_pulse();
        for (int i = 0; i < 20 && !(out_valid && out_pc == 8'h10); i++)
            tick();
        checks++;
        if (!(out_valid && out_pc == 8'h10)) begin
            failures++;
            $display("FAIL redir_reach: timeout, out_pc %h want 10", out_pc);
        end
        checks++;
        if (fetch_cnt !== 16'd4) begin
            failures++;
            $display("FAIL redir_cnt_before: got %0d want 4", fetch_cnt);
        end
        redirect_valid  = 1'b1;
        redirect_target = 8'h14;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || imem_addr !== 8'h14 ||
            fetch_cnt !== 16'd5) begin
            failures++;
            $display("FAIL redir_flush: got %b %h %0d want 0 14 5",
                     out_valid, imem_addr, fetch_cnt);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 8'h14 ||
            fetch_cnt !== 16'd5) begin
            failures++;
            $display("FAIL redir_target: got %b %h %0d want 1 14 5",
                     out_valid, out_pc, fetch_cnt);
        end
    endtask

    task automatic test_fault();
        do_reset();
        fill_nops();
        out_ready = 1'b1;
        start_pulse();
        tick();
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 8'h15;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (fault !== 1'b1 || fault_addr !== 8'h15 ||
            out_valid !== 1'b0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL fault_enter: got %b %h %b %b want 1 15 0 0",
                     fault, fault_addr, out_valid, halted);
        end
        start           = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 8'h20;
        repeat (3) tick();
        start          = 1'b0;
        redirect_valid = 1'b0;
        checks++;
        if (fault !== 1'b1 || out_valid !== 1'b0 ||
            imem_addr !== 8'h08 || fault_addr !== 8'h15) begin
            failures++;
            $display("FAIL fault_sticky: got %b %b %h %h want 1 0 08 15",
                     fault, out_valid, imem_addr, fault_addr);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (fault !== 1'b0 || fault_addr !== 8'h00) begin
            failures++;
            $display("FAIL fault_reset: got %b %h want 0 00",
                     fault, fault_addr);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_halt();
        do_reset();
        fill_nops();
        put_word(8'h30, 32'h00000073);
        out_ready = 1'b1;
        start_pulse();
        for (int i = 0; i < 30 && !(out_valid && out_pc == 8'h30); i++)
            tick();
        checks++;
        if (out_instr !== 32'h00000073 || halted !== 1'b1 ||
            imem_addr !== 8'h30 || out_pc !== 8'h30) begin
            failures++;
            $display("FAIL halt_enter: got %h %b %h %h want 00000073 1 30 30",
                     out_instr, halted, imem_addr, out_pc);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || halted !== 1'b1) begin
            failures++;
            $display("FAIL halt_drain: got %b %b want 0 1",
                     out_valid, halted);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || imem_addr !== 8'h30) begin
            failures++;
            $display("FAIL halt_noload: got %b %h want 0 30",
                     out_valid, imem_addr);
        end
        redirect_valid  = 1'b1;
        redirect_target = 8'h00;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (halted !== 1'b0 || out_valid !== 1'b0 ||
            imem_addr !== 8'h00) begin
            failures++;
            $display("FAIL halt_exit: got %b %b %h want 0 0 00",
                     halted, out_valid, imem_addr);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 8'h00) begin
            failures++;
            $display("FAIL halt_resume: got %b %h want 1 00",
                     out_valid, out_pc);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        fill_nops();
        put_word(8'hFC, 32'h00a00093);
        out_ready = 1'b1;
        start_pulse();
        redirect_valid  = 1'b1;
        redirect_target = 8'hFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        checks++;
        if (out_pc !== 8'hFC || out_instr !== 32'h00a00093) begin
            failures++;
            $display("FAIL wrap_fc: got %h %h want fc 00a00093",
                     out_pc, out_instr);
        end
        tick();
        checks++;
        if (out_pc !== 8'h00 || out_instr !== NOP ||
            imem_addr !== 8'h04) begin
            failures++;
            $display("FAIL wrap_00: got %h %h %h want 00 00000013 04",
                     out_pc, out_instr, imem_addr);
        end
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 8'h00 ||
            out_instr !== 32'h0 || fetch_cnt !== 16'd0 ||
            imem_addr !== 8'h00) begin
            failures++;
            $display("FAIL async_reset: got %b %h %h %0d %h want 0 00 0 0 00",
                     out_valid, out_pc, out_instr, fetch_cnt, imem_addr);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] r;
        int          nfail = 0;
        do_reset();
        for (int a = 0; a < 256; a += 4) begin
            r = $urandom;
            if ($urandom_range(0, 15) == 0) r[6:0] = OPC_SYSTEM;
            else if (r[6:0] == OPC_SYSTEM) r[0] = 1'b0;
            put_word(a, r);
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc % 150 == 149) begin
                do_reset();
                continue;
            end
            start          = ($urandom_range(0, 3) == 0);
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            r              = $urandom;
            redirect_target = ($urandom_range(0, 31) == 0) ?
                              r[7:0] : (r[7:0] & 8'hFC);
            model_step();
            tick();
            checks++;
            if (out_valid !== m_ov || out_instr !== m_instr ||
                out_pc !== 8'(m_opc) || imem_addr !== 8'(m_pc) ||
                halted !== (m_mode == 2) || fault !== (m_mode == 3) ||
                fault_addr !== 8'(m_fa) || fetch_cnt !== 16'(m_cnt)) begin
                failures++;
                nfail++;
                if (nfail <= 10)
                    $display("FAIL random_%0d: got v%b i%h p%h a%h h%b f%b fa%h c%0d want v%b i%h p%h a%h h%b f%b fa%h c%0d",
                             cyc, out_valid, out_instr, out_pc, imem_addr,
                             halted, fault, fault_addr, fetch_cnt,
                             m_ov, m_instr, 8'(m_opc), 8'(m_pc),
                             m_mode == 2, m_mode == 3, 8'(m_fa), m_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_fault();
        test_halt();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
